// File: rtl/banked_data_ram.sv
// Byte-addressable data RAM built from four 8-bit lanes, with a valid/ready request port
// and an in-order response pipeline of 1 or 2 stages.
module banked_data_ram #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic [7:0]            fault_count
);
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IDX_W;

  logic [7:0] mem [4][DEPTH];

  logic             stall;
  logic             accept;
  logic             req_fault;
  logic [IDX_W-1:0] idx;
  logic [3:0]       byte_en;
  logic [31:0]      wr_lanes;
  logic [31:0]      rd_word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;

  logic        s1_valid_q, s1_valid_d;
  logic        s1_fault_q, s1_fault_d;
  logic [31:0] s1_rdata_q, s1_rdata_d;
  logic [7:0]  fault_count_q, fault_count_d;

  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = !rst && !stall;
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[ADDR_WIDTH-1:2];
  assign rd_word   = {mem[3][idx], mem[2][idx], mem[1][idx], mem[0][idx]};
  assign ld_byte   = rd_word[8*req_addr[1:0] +: 8];
  assign ld_half   = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    req_fault = 1'b0;
    byte_en   = 4'b0000;
    wr_lanes  = req_wdata;
    ld_data   = rd_word;
    case (req_size)
      2'b00: begin
        byte_en  = 4'b0001 << req_addr[1:0];
        wr_lanes = {4{req_wdata[7:0]}};
        ld_data  = {{24{req_signed & ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        req_fault = req_addr[0];
        byte_en   = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes  = {2{req_wdata[15:0]}};
        ld_data   = {{16{req_signed & ld_half[15]}}, ld_half};
      end
      2'b10: begin
        req_fault = (req_addr[1:0] != 2'b00);
        byte_en   = 4'b1111;
      end
      default: req_fault = 1'b1;
    endcase
    if (req_fault) byte_en = 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (accept && req_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[i][idx] <= wr_lanes[8*i +: 8];
      end
    end
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_fault_d    = s1_fault_q;
    s1_rdata_d    = s1_rdata_q;
    fault_count_d = fault_count_q;
    if (!stall) begin
      s1_valid_d = accept;
      s1_fault_d = accept && req_fault;
      s1_rdata_d = (accept && !req_write && !req_fault) ? ld_data : 32'h0;
    end
    if (accept && req_fault && fault_count_q != 8'hFF) fault_count_d = fault_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_fault_q    <= 1'b0;
      s1_rdata_q    <= 32'h0;
      fault_count_q <= 8'h0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_fault_q    <= s1_fault_d;
      s1_rdata_q    <= s1_rdata_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign fault_count = fault_count_q;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic        s2_valid_q, s2_valid_d;
      logic        s2_fault_q, s2_fault_d;
      logic [31:0] s2_rdata_q, s2_rdata_d;

      always_comb begin
        s2_valid_d = stall ? s2_valid_q : s1_valid_q;
        s2_fault_d = stall ? s2_fault_q : s1_fault_q;
        s2_rdata_d = stall ? s2_rdata_q : s1_rdata_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid_q <= 1'b0;
          s2_fault_q <= 1'b0;
          s2_rdata_q <= 32'h0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_fault_q <= s2_fault_d;
          s2_rdata_q <= s2_rdata_d;
        end
      end

      assign rsp_valid = s2_valid_q;
      assign rsp_fault = s2_fault_q;
      assign rsp_rdata = s2_rdata_q;
    end else begin : g_lat1
      assign rsp_valid = s1_valid_q;
      assign rsp_fault = s1_fault_q;
      assign rsp_rdata = s1_rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_banked_data_ram.sv
// Scoreboard bench: a 2-stage instance (with response back-pressure) and a 1-stage instance
// (always ready) see the same accepted requests and are checked against a byte-array model.
module tb_banked_data_ram;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid, req_write, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_valid_b;
  logic          req_ready_a, req_ready_b;
  logic          rsp_valid_a, rsp_valid_b;
  logic          rsp_ready_a, rsp_ready_b;
  logic          rsp_fault_a, rsp_fault_b;
  logic [31:0]   rsp_rdata_a, rsp_rdata_b;
  logic [7:0]    fault_count_a, fault_count_b;

  int hold_cycles;
  int cyc;
  bit lat_on;
  int n_cmp, n_err;
  int fc_m;
  logic [7:0] mem_m [1024];

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          acc;
    bit          lat;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];

  assign rsp_ready_a = (hold_cycles == 0);
  assign rsp_ready_b = 1'b1;
  // The 1-stage copy only sees a request on the edge the 2-stage copy accepts it.
  assign req_valid_b = req_valid && req_ready_a;

  banked_data_ram #(.ADDR_WIDTH(AW), .READ_LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_a),
    .rsp_ready(rsp_ready_a), .rsp_rdata(rsp_rdata_a), .rsp_fault(rsp_fault_a),
    .fault_count(fault_count_a)
  );

  banked_data_ram #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_b),
    .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b), .rsp_fault(rsp_fault_b),
    .fault_count(fault_count_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_op(input logic wr, input logic [1:0] sz, input logic sg,
                                    input logic [AW-1:0] ad, input logic [31:0] wd);
    exp_t e;
    int a;
    logic [31:0] w;
    a = int'(ad);
    w = 32'h0;
    e.fault = (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00);
    e.acc = cyc;
    e.lat = lat_on;
    if (e.fault) begin
      if (fc_m < 255) fc_m++;
    end else if (wr) begin
      mem_m[a] = wd[7:0];
      if (sz != 2'b00) mem_m[a+1] = wd[15:8];
      if (sz == 2'b10) begin
        mem_m[a+2] = wd[23:16];
        mem_m[a+3] = wd[31:24];
      end
    end else begin
      case (sz)
        2'b00: begin
          w = {24'h0, mem_m[a]};
          if (sg && w[7]) w[31:8] = 24'hFFFFFF;
        end
        2'b01: begin
          w = {16'h0, mem_m[a+1], mem_m[a]};
          if (sg && w[15]) w[31:16] = 16'hFFFF;
        end
        default: w = {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
      endcase
    end
    e.data = w;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hold_cycles > 0) hold_cycles--;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check_eq("a_ready_in_rst", {31'h0, req_ready_a}, 32'h0);
    end else begin
      check_eq("a_ready_rule", {31'h0, req_ready_a}, {31'h0, !(rsp_valid_a && !rsp_ready_a)});
      if (rsp_valid_a && rsp_ready_a) begin
        if (q_a.size() == 0) begin
          check_eq("a_unexpected_rsp", {31'h0, rsp_valid_a}, 32'h0);
        end else begin
          e = q_a.pop_front();
          check_eq("a_rdata", rsp_rdata_a, e.data);
          check_eq("a_fault", {31'h0, rsp_fault_a}, {31'h0, e.fault});
          if (e.lat) check_eq("a_latency", cyc - e.acc, 32'd1);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid_b && rsp_ready_b) begin
      if (q_b.size() == 0) begin
        check_eq("b_unexpected_rsp", {31'h0, rsp_valid_b}, 32'h0);
      end else begin
        e = q_b.pop_front();
        check_eq("b_rdata", rsp_rdata_b, e.data);
        check_eq("b_fault", {31'h0, rsp_fault_b}, {31'h0, e.fault});
        check_eq("b_latency", cyc - e.acc, 32'd0);
      end
    end
  end

  task automatic send(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [AW-1:0] ad, input logic [31:0] wd);
    exp_t e;
    bit ok;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    req_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_eq("req_ready_timeout", {31'h0, req_ready_a}, 32'h1);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    @(posedge clk);
    #1;
    e = model_op(wr, sz, sg, ad, wd);
    q_a.push_back(e);
    q_b.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) return;
      @(posedge clk);
      #1;
    end
    check_eq("drain_timeout", q_a.size() + q_b.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [1:0]    rs;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = 32'h0;
    hold_cycles = 0;
    lat_on = 1'b1;
    fc_m = 0;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rsp_valid_a", {31'h0, rsp_valid_a}, 32'h0);
    check_eq("rst_rsp_valid_b", {31'h0, rsp_valid_b}, 32'h0);
    check_eq("rst_rdata_a", rsp_rdata_a, 32'h0);
    check_eq("rst_fault_count_a", {24'h0, fault_count_a}, 32'h0);
    check_eq("rst_fault_count_b", {24'h0, fault_count_b}, 32'h0);
    rst = 1'b0;

    send(1'b1, 2'b10, 1'b0, 10'h010, 32'h89ABCDEF);
    send(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    send(1'b0, 2'b00, 1'b1, 10'h013, 32'h0);
    send(1'b0, 2'b00, 1'b0, 10'h013, 32'h0);
    send(1'b0, 2'b01, 1'b1, 10'h010, 32'h0);
    send(1'b0, 2'b01, 1'b0, 10'h012, 32'h0);
    send(1'b0, 2'b00, 1'b1, 10'h010, 32'h0);
    send(1'b0, 2'b10, 1'b1, 10'h010, 32'h0);

    send(1'b1, 2'b01, 1'b0, 10'h012, 32'h00001234);
    send(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);

    send(1'b0, 2'b10, 1'b0, 10'h011, 32'h0);
    send(1'b0, 2'b01, 1'b0, 10'h003, 32'h0);
    send(1'b0, 2'b11, 1'b0, 10'h010, 32'h0);
    check_eq("fault_count_3_a", {24'h0, fault_count_a}, 32'd3);
    check_eq("fault_count_3_b", {24'h0, fault_count_b}, 32'd3);
    send(1'b1, 2'b10, 1'b0, 10'h012, 32'hDEADBEEF);
    send(1'b1, 2'b01, 1'b0, 10'h011, 32'h0000BEEF);
    send(1'b1, 2'b11, 1'b0, 10'h010, 32'hFFFFFFFF);
    send(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    check_eq("fault_count_6_a", {24'h0, fault_count_a}, 32'd6);

    send(1'b1, 2'b00, 1'b0, 10'h020, 32'hFFFFFFA5);
    send(1'b1, 2'b00, 1'b0, 10'h021, 32'h0000005A);
    send(1'b1, 2'b00, 1'b0, 10'h022, 32'h1234563C);
    send(1'b1, 2'b00, 1'b0, 10'h023, 32'h000000C3);
    send(1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
    send(1'b0, 2'b01, 1'b1, 10'h022, 32'h0);
    send(1'b0, 2'b00, 1'b1, 10'h021, 32'h0);

    for (int i = 0; i < 16; i++) send(1'b1, 2'b10, 1'b0, AW'(10'h100 + 4*i), $urandom);
    for (int i = 0; i < 24; i++) begin
      rs = 2'($urandom_range(0, 2));
      ra = AW'(10'h100 + 4*$urandom_range(0, 15));
      if (rs == 2'b00) ra[1:0] = 2'($urandom_range(0, 3));
      if (rs == 2'b01) ra[1] = 1'($urandom_range(0, 1));
      send(1'b0, rs, 1'($urandom_range(0, 1)), ra, 32'h0);
    end
    drain();

    lat_on = 1'b0;
    hold_cycles = 3;
    for (int i = 0; i < 6; i++) send(1'b0, 2'b10, 1'b0, AW'(10'h100 + 4*i), 32'h0);
    hold_cycles = 4;
    send(1'b1, 2'b00, 1'b0, 10'h104, 32'h00000077);
    send(1'b0, 2'b10, 1'b0, 10'h104, 32'h0);
    send(1'b0, 2'b00, 1'b1, 10'h104, 32'h0);
    drain();
    lat_on = 1'b1;

    for (int i = 0; i < 260; i++) send(1'b0, 2'b11, 1'b0, 10'h040, 32'h0);
    check_eq("fault_count_sat_a", {24'h0, fault_count_a}, 32'd255);
    check_eq("fault_count_sat_b", {24'h0, fault_count_b}, 32'd255);
    drain();

    lat_on = 1'b0;
    hold_cycles = 20;
    send(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    send(1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
    rst = 1'b1;
    q_a.delete();
    q_b.delete();
    fc_m = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_rst_rsp_valid_a", {31'h0, rsp_valid_a}, 32'h0);
    check_eq("mid_rst_rsp_valid_b", {31'h0, rsp_valid_b}, 32'h0);
    check_eq("mid_rst_fault_count_a", {24'h0, fault_count_a}, 32'h0);
    check_eq("mid_rst_fault_count_b", {24'h0, fault_count_b}, 32'h0);
    hold_cycles = 0;
    rst = 1'b0;
    lat_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    send(1'b0, 2'b10, 1'b0, 10'h020, 32'h0);
    drain();
    repeat (4) @(posedge clk);
    #1;
    check_eq("final_queue_a", q_a.size(), 32'h0);
    check_eq("final_queue_b", q_b.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
